// File: rtl/ex_weights_seg_ctrl_if.sv
// Command, load-stream, fetch-stream and segment-memory signals of the weight segment controller.
// rd_rep exists only when WSEG_REPEAT_EN is defined.
interface ex_weights_seg_ctrl_if #(
    parameter int BITSIZE = 14
);
    logic               ld_start;
    logic               rd_start;
    logic [9:0]         base;
    logic [9:0]         len;
`ifdef WSEG_REPEAT_EN
    logic [3:0]         rd_rep;
`endif
    logic               ld_valid;
    logic [BITSIZE-1:0] ld_data;
    logic               ld_ready;
    logic               w_valid;
    logic [BITSIZE-1:0] w_data;
    logic               w_last;
    logic               busy;
    logic               done;
    logic [9:0]         mem_index;
    logic               mem_en;
    logic               mem_rd;
    logic               mem_wr;
    logic [BITSIZE-1:0] mem_din;
    logic [BITSIZE-1:0] mem_dout;

    modport master (
`ifdef WSEG_REPEAT_EN
        output rd_rep,
`endif
        output ld_start, rd_start, base, len, ld_valid, ld_data, mem_dout,
        input  ld_ready, w_valid, w_data, w_last, busy, done,
        input  mem_index, mem_en, mem_rd, mem_wr, mem_din
    );

    modport slave (
`ifdef WSEG_REPEAT_EN
        input  rd_rep,
`endif
        input  ld_start, rd_start, base, len, ld_valid, ld_data, mem_dout,
        output ld_ready, w_valid, w_data, w_last, busy, done,
        output mem_index, mem_en, mem_rd, mem_wr, mem_din
    );
endinterface

// File: rtl/ex_weights_seg_ctrl.sv
// Weight segment controller: streams a block of words into the segment (LOAD) or out of it (FETCH, 1-cycle read latency).
// Optional WSEG_REPEAT_EN: rd_rep replays the fetch block rd_rep+1 times back-to-back.
module ex_weights_seg_ctrl #(
    parameter int HEIGHT  = 32,
    parameter int BITSIZE = 14
) (
    input  logic                 clk,
    input  logic                 rst,
    ex_weights_seg_ctrl_if.slave bus
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_LOAD  = 2'd1;
    localparam logic [1:0] S_FETCH = 2'd2;
    localparam logic [1:0] S_DRAIN = 2'd3;

    localparam logic [9:0] ROW_LAST = 10'(HEIGHT - 1);

    logic [1:0] state;
    logic [9:0] row;
    logic [9:0] base_q;
    logic [9:0] len_q;
    logic [9:0] cnt;
    logic       done_q;
    logic       w_valid_q;
`ifdef WSEG_REPEAT_EN
    logic [3:0] rep_q;
    logic [3:0] pass;
`endif

    logic [9:0] base_mod;
    logic [9:0] row_next;
    logic       last_word;
    logic       wr_fire;
    logic       rd_fire;
    logic       start;

    assign base_mod  = 10'(bus.base % 10'(HEIGHT));
    assign row_next  = (row == ROW_LAST) ? 10'd0 : row + 10'd1;
    assign last_word = (cnt == len_q - 10'd1);
    assign start     = bus.ld_start | bus.rd_start;

    // Strobes are masked while rst is high so an aborted command cannot touch the segment.
    assign wr_fire = ~rst & (state == S_LOAD) & bus.ld_valid;
    assign rd_fire = ~rst & (state == S_FETCH);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            row       <= 10'd0;
            base_q    <= 10'd0;
            len_q     <= 10'd0;
            cnt       <= 10'd0;
            done_q    <= 1'b0;
            w_valid_q <= 1'b0;
`ifdef WSEG_REPEAT_EN
            rep_q     <= 4'd0;
            pass      <= 4'd0;
`endif
        end else begin
            done_q    <= 1'b0;
            w_valid_q <= rd_fire;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        base_q <= base_mod;
                        row    <= base_mod;
                        len_q  <= bus.len;
                        cnt    <= 10'd0;
`ifdef WSEG_REPEAT_EN
                        rep_q  <= bus.ld_start ? 4'd0 : bus.rd_rep;
                        pass   <= 4'd0;
`endif
                        if (bus.len == 10'd0)
                            done_q <= 1'b1;
                        else
                            state <= bus.ld_start ? S_LOAD : S_FETCH;
                    end
                end
                S_LOAD: begin
                    if (wr_fire) begin
                        row <= row_next;
                        cnt <= cnt + 10'd1;
                        if (last_word) begin
                            state  <= S_IDLE;
                            done_q <= 1'b1;
                        end
                    end
                end
                S_FETCH: begin
                    row <= row_next;
                    cnt <= cnt + 10'd1;
                    if (last_word) begin
`ifdef WSEG_REPEAT_EN
                        if (pass != rep_q) begin
                            row  <= base_q;
                            cnt  <= 10'd0;
                            pass <= pass + 4'd1;
                        end else begin
                            state <= S_DRAIN;
                        end
`else
                        state <= S_DRAIN;
`endif
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.ld_ready  = ~rst & (state == S_LOAD);
    assign bus.mem_en    = wr_fire | rd_fire;
    assign bus.mem_wr    = wr_fire;
    assign bus.mem_rd    = rd_fire;
    assign bus.mem_index = (wr_fire | rd_fire) ? row : 10'd0;
    assign bus.mem_din   = wr_fire ? bus.ld_data : '0;

    // DRAIN is exactly the cycle carrying the final read's data.
    assign bus.w_valid = w_valid_q;
    assign bus.w_data  = w_valid_q ? bus.mem_dout : '0;
    assign bus.w_last  = (state == S_DRAIN);
    assign bus.busy    = (state != S_IDLE);
    assign bus.done    = done_q | (state == S_DRAIN);
endmodule

// File: tb/tb_ex_weights_seg_ctrl.sv
// Randomized bench for ex_weights_seg_ctrl against an array-based segment model and index/data expectations.
module tb_ex_weights_seg_ctrl;
    localparam int H  = 32;
    localparam int BW = 14;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ex_weights_seg_ctrl_if #(.BITSIZE(BW)) bus ();

    ex_weights_seg_ctrl #(.HEIGHT(H), .BITSIZE(BW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Segment storage seen by the DUT, and the bench's own record of what each row must hold.
    logic [BW-1:0] seg     [H];
    logic [BW-1:0] ref_mem [H];
    logic [BW-1:0] dq [$];

    always @(posedge clk) begin
        if (bus.mem_en && bus.mem_wr) seg[bus.mem_index % H] <= bus.mem_din;
        if (bus.mem_en && bus.mem_rd) bus.mem_dout <= seg[bus.mem_index % H];
    end

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        bus.ld_start = 1'b0;
        bus.rd_start = 1'b0;
        bus.ld_valid = 1'b0;
        bus.ld_data  = '0;
`ifdef WSEG_REPEAT_EN
        bus.rd_rep   = 4'd0;
`endif
    endtask

    // gap_pct < 0 selects the directed pattern: one invalid cycle before the third word.
    task automatic do_load(input int b, input int n, input bit with_rd, input int gap_pct);
        int k, cyc, r;
        bit v;
        logic [BW-1:0] d;
        @(posedge clk); #1;
        bus.ld_start = 1'b1;
        bus.rd_start = with_rd;
        bus.base     = 10'(b);
        bus.len      = 10'(n);
        @(negedge clk);
        check("ld_start_no_strobe", bus.mem_en, 0);
        @(posedge clk); #1;
        idle_inputs();
        if (n == 0) begin
            @(negedge clk);
            check("ld_len0_done", bus.done, 1);
            check("ld_len0_busy", bus.busy, 0);
            check("ld_len0_strobe", bus.mem_en, 0);
            return;
        end
        k = 0;
        cyc = 0;
        while (k < n && cyc < 200) begin
            v = (gap_pct < 0) ? (cyc != 2) : ($urandom_range(99) >= gap_pct);
            d = (dq.size() > 0 && v) ? dq[0] : BW'($urandom);
            bus.ld_valid = v;
            bus.ld_data  = d;
            bus.rd_start = ($urandom_range(3) == 0);
            bus.ld_start = ($urandom_range(5) == 0);
            bus.base     = 10'($urandom);
            bus.len      = 10'($urandom);
            @(negedge clk);
            check("ld_busy", bus.busy, 1);
            check("ld_ready", bus.ld_ready, 1);
            check("ld_no_rd", bus.mem_rd, 0);
            check("ld_wr", bus.mem_wr, v);
            if (v) begin
                r = ((b % H) + k) % H;
                check("ld_index", bus.mem_index, r);
                check("ld_din", bus.mem_din, d);
                ref_mem[r] = d;
                if (dq.size() > 0) void'(dq.pop_front());
                k++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        idle_inputs();
        check("ld_words", k, n);
        @(negedge clk);
        check("ld_done", bus.done, 1);
        check("ld_busy_end", bus.busy, 0);
        check("ld_ready_end", bus.ld_ready, 0);
        check("ld_end_strobe", bus.mem_en, 0);
    endtask

    task automatic do_fetch(input int b, input int n, input int rep);
        int total, b0, idx;
        int iq [$];
        total = n * (rep + 1);
        b0 = b % H;
        @(posedge clk); #1;
        bus.rd_start = 1'b1;
        bus.base     = 10'(b);
        bus.len      = 10'(n);
`ifdef WSEG_REPEAT_EN
        bus.rd_rep   = 4'(rep);
`endif
        @(negedge clk);
        check("rd_start_no_strobe", bus.mem_en, 0);
        if (n == 0) begin
            @(posedge clk); #1;
            idle_inputs();
            @(negedge clk);
            check("rd_len0_done", bus.done, 1);
            check("rd_len0_busy", bus.busy, 0);
            check("rd_len0_strobe", bus.mem_en, 0);
            return;
        end
        for (int j = 1; j <= total + 1; j++) begin
            @(posedge clk); #1;
            idle_inputs();
            bus.rd_start = ($urandom_range(3) == 0);
            bus.ld_start = ($urandom_range(3) == 0);
            bus.ld_valid = ($urandom_range(1) == 0);
            bus.base     = 10'($urandom);
            bus.len      = 10'($urandom);
            @(negedge clk);
            check("rd_busy", bus.busy, 1);
            check("rd_no_ldrdy", bus.ld_ready, 0);
            check("rd_no_wr", bus.mem_wr, 0);
            if (j <= total) begin
                idx = (b0 + ((j - 1) % n)) % H;
                check("rd_strobe", bus.mem_rd, 1);
                check("rd_index", bus.mem_index, idx);
                iq.push_back(idx);
            end else begin
                check("rd_drain_no_strobe", bus.mem_en, 0);
            end
            check("rd_w_valid", bus.w_valid, (j >= 2));
            if (j >= 2) check("rd_w_data", bus.w_data, ref_mem[iq.pop_front()]);
            check("rd_w_last", bus.w_last, (j == total + 1));
            check("rd_done", bus.done, (j == total + 1));
        end
        @(posedge clk); #1;
        idle_inputs();
        @(negedge clk);
        check("rd_busy_end", bus.busy, 0);
        check("rd_w_valid_end", bus.w_valid, 0);
        check("rd_done_end", bus.done, 0);
    endtask

    initial begin
        idle_inputs();
        bus.base = '0;
        bus.len  = '0;
        for (int i = 0; i < H; i++) ref_mem[i] = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ld_ready", bus.ld_ready, 0);
        check("rst_w_valid", bus.w_valid, 0);
        check("rst_w_last", bus.w_last, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_mem_en", bus.mem_en, 0);
        check("rst_mem_rd", bus.mem_rd, 0);
        check("rst_mem_wr", bus.mem_wr, 0);
        check("rst_mem_index", bus.mem_index, 0);
        check("rst_mem_din", bus.mem_din, 0);
        check("rst_w_data", bus.w_data, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Fill every row so later fetches read known contents.
        do_load(0, H, 1'b0, 20);

        dq = '{14'd5, 14'h3FFD, 14'd7, 14'd100};
        do_load(0, 4, 1'b1, -1);
        do_fetch(0, 4, 0);
        check("dir_row1_neg3", ref_mem[1], 14'h3FFD);

        do_fetch(30, 4, 0);
        do_fetch(100, 5, 0);
        do_load(5, 0, 1'b0, 0);
        do_fetch(7, 0, 0);

        // Reset on the second read of an 8-word fetch.
        @(posedge clk); #1;
        bus.rd_start = 1'b1;
        bus.base     = 10'd0;
        bus.len      = 10'd8;
        @(posedge clk); #1;
        idle_inputs();
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_no_strobe", bus.mem_en, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_mid_w_valid", bus.w_valid, 0);
        check("rst_mid_w_last", bus.w_last, 0);
        check("rst_mid_busy", bus.busy, 0);
        check("rst_mid_done", bus.done, 0);
        check("rst_mid_mem_en", bus.mem_en, 0);
        @(negedge clk);
        check("rst_mid_no_late_done", bus.done, 0);
        do_fetch(0, 8, 0);

        // Reset during a load: three words land, the rest of the block keeps its old contents.
        @(posedge clk); #1;
        bus.ld_start = 1'b1;
        bus.base     = 10'd10;
        bus.len      = 10'd6;
        @(posedge clk); #1;
        idle_inputs();
        for (int k = 0; k < 3; k++) begin
            bus.ld_valid = 1'b1;
            bus.ld_data  = BW'($urandom);
            @(negedge clk);
            check("abort_ld_index", bus.mem_index, 10 + k);
            if (bus.mem_wr) ref_mem[10 + k] = bus.ld_data;
            @(posedge clk); #1;
        end
        bus.ld_data = BW'($urandom);
        rst = 1'b1;
        @(negedge clk);
        check("abort_ld_no_wr", bus.mem_wr, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        idle_inputs();
        @(negedge clk);
        check("abort_ld_busy", bus.busy, 0);
        check("abort_ld_done", bus.done, 0);
        do_fetch(10, 6, 0);

`ifdef WSEG_REPEAT_EN
        do_fetch(4, 2, 2);
`endif

        for (int it = 0; it < 8; it++) begin
            do_load($urandom_range(1023), $urandom_range(12), $urandom_range(1), 30);
`ifdef WSEG_REPEAT_EN
            do_fetch($urandom_range(1023), $urandom_range(10), $urandom_range(3));
`else
            do_fetch($urandom_range(1023), $urandom_range(10), 0);
`endif
        end

        $display("[TB] %0d tests run, %0d failed", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/ex_weights_seg_ctrl.md
EX_WEIGHTS_SEG_CTRL -- requirements
Module: ex_weights_seg_ctrl

Interface
REQ-001 Parameter: HEIGHT, 32, number of rows in the controlled weight segment.
REQ-002 Parameter: BITSIZE, 14, signed weight width.
REQ-003 Port: clk  in  1  rising-edge clock, sole clock domain.
REQ-004 Port: rst  in  1  reset, synchronous, active-high.
REQ-005 Port: ld_start  in  1  one-cycle request to load a weight block.
REQ-006 Port: rd_start  in  1  one-cycle request to fetch a weight block.
REQ-007 Port: base  in  10  first row of the block, sampled on accepted start.
REQ-008 Port: len  in  10  word count of the block, sampled on accepted start.
REQ-009 Port: ld_valid  in  1  load word valid.
REQ-010 Port: ld_data  in  BITSIZE  signed load word.
REQ-011 Port: ld_ready  out  1  controller accepts load words.
REQ-012 Port: w_valid  out  1  fetched weight valid.
REQ-013 Port: w_data  out  BITSIZE  fetched signed weight.
REQ-014 Port: w_last  out  1  final fetched word of the command.
REQ-015 Port: busy  out  1  command in progress (state not IDLE).
REQ-016 Port: done  out  1  one-cycle completion pulse.
REQ-017 Port: mem_index / mem_en / mem_rd / mem_wr  out  10/1/1/1  segment address and strobes.
REQ-018 Port: mem_din  out  BITSIZE; mem_dout  in  BITSIZE  segment write/read data; segment read latency is 1 cycle.

Function
REQ-019 FSM states SHALL be IDLE, LOAD, FETCH, DRAIN.
REQ-020 In IDLE, ld_start SHALL win over simultaneous rd_start; rd_start SHALL then be dropped.
REQ-021 Starts received outside IDLE SHALL be ignored with no side effect.
REQ-022 Accepted start with len=0 SHALL stay IDLE, issue no memory strobe, and pulse done the next cycle.
REQ-023 LOAD: ld_ready=1; each ld_valid&ld_ready cycle SHALL drive mem_en=mem_wr=1, mem_din=ld_data, mem_index=current row, same cycle.
REQ-024 LOAD SHALL exit to IDLE after the len-th write, pulsing done the following cycle; ld_ready SHALL be 0 outside LOAD.
REQ-025 FETCH: SHALL issue mem_en=mem_rd=1 every cycle, one row per cycle, no gaps, first read the cycle after rd_start.
REQ-026 w_valid SHALL assert exactly one cycle after each read issue with w_data=mem_dout.
REQ-027 After the final read FETCH SHALL go to DRAIN for one cycle; w_last and done SHALL pulse with the final w_valid; then IDLE.
REQ-028 Row pointer SHALL start at base and increment by 1; after HEIGHT-1 it SHALL wrap to 0; base>=HEIGHT SHALL be reduced modulo HEIGHT on sampling.
REQ-029 mem_rd and mem_wr SHALL never both be 1; mem_en SHALL be 0 whenever no strobe is issued.
REQ-030 busy SHALL be 1 from the cycle after an accepted nonzero start until return to IDLE.

Reset
REQ-031 On rst: state IDLE, counters 0, all outputs 0 (ld_ready, w_valid, w_last, busy, done, mem_en, mem_rd, mem_wr, mem_index, mem_din, w_data).
REQ-032 rst mid-command SHALL abort it without done; segment contents already written SHALL be left unchanged; no strobe in the reset cycle.

Configuration
REQ-033 Macro WSEG_REPEAT_EN defined: adds input rd_rep (4 bits, sampled with rd_start); the fetch block SHALL be replayed rd_rep+1 times back-to-back with no bubble, restarting at base; w_last only on final word of final pass.
REQ-034 Macro undefined: rd_rep port absent; exactly one pass per fetch.

Verification
REQ-035 Load base=0,len=4, ld_data 5,-3,7,100 with ld_valid gap after word 2 -> writes rows 0..3 only on valid cycles; done one cycle after 4th write.
REQ-036 Fetch base=0,len=4 -> mem_rd cycles T+1..T+4, w_valid T+2..T+5 with 5,-3,7,100; w_last+done at T+5.
REQ-037 HEIGHT=32, fetch base=30,len=4 -> mem_index 30,31,0,1.
REQ-038 ld_start and rd_start same cycle -> LOAD entered, no read strobe; rd_start during LOAD ignored.
REQ-039 rst asserted at 2nd read of len=8 fetch -> next cycle all outputs 0, no done; new fetch then completes normally.
REQ-040 With WSEG_REPEAT_EN, base=4,len=2,rd_rep=2 -> indices 4,5,4,5,4,5; single w_last on 6th word.
